// File: rtl/sobol_ctrl_pkg.sv
// Shared types and helpers for the Sobol epoch arbiter.
package sobol_ctrl_pkg;

  // Default RNG output width, matching the sobolrng instance.
  localparam int unsigned DefBitwidth = 8;

  // Widest requester vector rr_next can search.
  localparam int unsigned MaxReq = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } epoch_state_e;

  // Round-robin search: first set bit of req at or above ptr, wrapping modulo nreq.
  // Returns ptr when no bit is set; callers qualify with |req.
  function automatic logic [3:0] rr_next(input logic [3:0]        ptr,
                                         input logic [MaxReq-1:0] req,
                                         input int unsigned       nreq);
    logic [3:0]  win;
    logic        found;
    int unsigned idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (!found && (i < nreq) && req[idx[3:0]]) begin
        win   = idx[3:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
module rr_arbiter
  import sobol_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    any
);

  logic [MaxReq-1:0] req_ext;
  logic [3:0]        win;

  // Widen to the helper's fixed search width, pick, and decode to one-hot.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    win                = rr_next(4'(ptr), req_ext, NREQ);
    any                = |req;
    gnt                = any ? (NREQ'(1) << win) : '0;
  end

endmodule

// File: rtl/sobol_epoch_arbiter.sv
// Grants one shared sobolrng to a single lane for a whole epoch of EPOCH_LEN samples.
module sobol_epoch_arbiter
  import sobol_ctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BITWIDTH  = DefBitwidth,
  parameter int unsigned EPOCH_LEN = 2 ** BITWIDTH
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [NREQ-1:0]              iReq,
  input  logic [NREQ-1:0]              iStall,
  output logic [NREQ-1:0]              oGnt,
  output logic                         oRngEn,
  output logic                         oRngClr,
  output logic                         oValid,
  output logic [$clog2(EPOCH_LEN)-1:0] oCnt,
  output logic                         oDone,
  output logic                         oAborted
);

  localparam int unsigned  CntW    = $clog2(EPOCH_LEN);
  localparam int unsigned  PtrW    = $clog2(NREQ);
  localparam logic [CntW-1:0] CntLast = CntW'(EPOCH_LEN - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(NREQ - 1);

  epoch_state_e    state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            aborted_q, aborted_d;

  logic [NREQ-1:0] arb_gnt;
  logic            arb_any;
  logic            g_req;
  logic            g_stall;
  logic [PtrW-1:0] gnt_idx;
  logic [PtrW-1:0] ptr_next;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req(iReq),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .any(arb_any)
  );

  // Owner's request/stall bits and its index, used for the post-epoch pointer advance.
  always_comb begin
    g_req   = |(iReq & gnt_q);
    g_stall = |(iStall & gnt_q);
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) gnt_idx = PtrW'(i);
    end
    ptr_next = (gnt_idx == PtrLast) ? '0 : gnt_idx + PtrW'(1);
  end

  // Epoch FSM: next state and outputs. Only iReq/iStall reach oValid/oRngEn combinationally.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    oGnt      = '0;
    oRngEn    = 1'b0;
    oRngClr   = 1'b0;
    oValid    = 1'b0;
    oDone     = 1'b0;
    oAborted  = 1'b0;
    oCnt      = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d     = arb_gnt;
          cnt_d     = '0;
          aborted_d = 1'b0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        oGnt    = gnt_q;
        oRngClr = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        oGnt = gnt_q;
        // A dropped request wins over a simultaneous final sample.
        if (!g_req) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (!g_stall) begin
          oValid = 1'b1;
          oRngEn = 1'b1;
          if (cnt_q == CntLast) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      DONE: begin
        oDone    = 1'b1;
        oAborted = aborted_q;
        ptr_d    = ptr_next;
        gnt_d    = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset mid-epoch simply discards it.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

endmodule

// File: tb/tb_sobol_epoch_arbiter.sv
// Randomized self-checking bench against a cycle-level behavioural model of the epoch arbiter.
module tb_sobol_epoch_arbiter;

  localparam int NReq  = 4;
  localparam int Bw    = 8;
  localparam int Epoch = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] stall = '0;

  logic [3:0] gnt;
  logic       rng_en;
  logic       rng_clr;
  logic       valid;
  logic [2:0] cnt;
  logic       done;
  logic       aborted;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: owner lane (-1 none), cycles since grant, sample index,
  // pending end (0 none, 1 normal, 2 aborted) and round-robin pointer.
  int m_owner = -1;
  int m_age   = 0;
  int m_cnt   = 0;
  int m_end   = 0;
  int m_ptr   = 0;

  sobol_epoch_arbiter #(
    .NREQ(NReq),
    .BITWIDTH(Bw),
    .EPOCH_LEN(Epoch)
  ) u_dut (
    .iClk(clk),
    .iRst(rst),
    .iReq(req),
    .iStall(stall),
    .oGnt(gnt),
    .oRngEn(rng_en),
    .oRngClr(rng_clr),
    .oValid(valid),
    .oCnt(cnt),
    .oDone(done),
    .oAborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected outputs for the current cycle given model state and current inputs.
  task automatic check_outputs();
    logic [3:0] e_gnt;
    logic       e_clr, e_valid, e_done, e_ab;
    e_gnt = '0; e_clr = 1'b0; e_valid = 1'b0; e_done = 1'b0; e_ab = 1'b0;
    if (m_end != 0) begin
      e_done = 1'b1;
      e_ab   = (m_end == 2);
    end else if (m_owner >= 0) begin
      e_gnt = 4'(1 << m_owner);
      if (m_age == 0) e_clr = 1'b1;
      else e_valid = req[m_owner] && !stall[m_owner];
    end
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rng_clr", 32'(rng_clr), 32'(e_clr));
    check("rng_en", 32'(rng_en), 32'(e_valid));
    check("valid", 32'(valid), 32'(e_valid));
    check("done", 32'(done), 32'(e_done));
    if (e_done) check("aborted", 32'(aborted), 32'(e_ab));
    if (e_valid || e_clr) check("cnt", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic model_step();
    bit found;
    if (rst) begin
      m_owner = -1; m_age = 0; m_cnt = 0; m_end = 0; m_ptr = 0;
    end else if (m_end != 0) begin
      m_ptr   = (m_owner + 1) % NReq;
      m_owner = -1;
      m_end   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < NReq; k++) begin
        int c;
        c = (m_ptr + k) % NReq;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_age   = 0;
          m_cnt   = 0;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (!req[m_owner]) begin
      m_end = 2;
    end else if (!stall[m_owner]) begin
      if (m_cnt == Epoch - 1) m_end = 1;
      else m_cnt++;
    end
  endtask

  // One clock: drive after the edge, check mid-cycle, then advance the model.
  task automatic cycle(input logic r, input logic [3:0] q, input logic [3:0] s);
    @(posedge clk);
    #1;
    rst   = r;
    req   = q;
    stall = s;
    @(negedge clk);
    check_outputs();
    model_step();
  endtask

  initial begin
    logic [3:0] q;
    logic [3:0] s;
    bit         hit;
    repeat (2) @(posedge clk);

    // Reset state, then all lanes requesting continuously: round-robin order.
    cycle(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 60; i++) cycle(1'b0, 4'b1111, 4'b0000);

    // Lane 0 alone; drop its request exactly on the unstalled final sample.
    cycle(1'b1, 4'b0000, 4'b0000);
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!hit && m_owner == 0 && m_age == 1 && m_cnt == Epoch - 1 && m_end == 0) begin
        hit = 1'b1;
        cycle(1'b0, 4'b0000, 4'b0000);
      end else begin
        cycle(1'b0, hit ? 4'b0000 : 4'b0001, 4'b0000);
      end
    end
    check("final_drop_reached", 32'(hit), 32'd1);

    // Lane 2 stalls on its final sample for a few cycles before completing.
    cycle(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 30; i++) begin
      s = (m_owner == 2 && m_cnt == Epoch - 1 && i < 16) ? 4'b0100 : 4'b0000;
      cycle(1'b0, 4'b0100, s);
    end

    // Random requests, stalls and occasional resets.
    q = 4'b0000;
    for (int i = 0; i < 2000; i++) begin
      for (int l = 0; l < NReq; l++) begin
        if ($urandom_range(0, 19) == 0) q[l] = ~q[l];
        s[l] = ($urandom_range(0, 3) == 0);
      end
      cycle(($urandom_range(0, 149) == 0), q, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
